controlador_segmentos: RTL and testbench
========================================

# controlador_segmentos

Sequencer for the 7-segment decoder. It produces the 2-bit display state code `st` and the 2-bit animation phase `freq`.

- `freq` comes from an internal prescaler and wraps every 4 ticks; one full `freq` wrap is one *frame*.
- `st` changes only on frame boundaries, so every animation frame plays to completion.
- New state requests enter through a one-entry valid/ready buffer; a force path applies a request immediately.
- The block sits between the system control logic and the segment decoder, whose `ST`/`FREQ` inputs it drives directly.

## Interface

Parameters:
- `DIV`, default 4: clock cycles per `freq` step; legal range ≥1.
- `MIN_FRAMES`, default 1: complete frames the current state must show before a pending request may replace it; legal range ≥1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: a new state request is present.
- `req_st` in 2: requested state code.
- `req_force` in 1: qualifies `req_valid`; apply the request immediately, bypassing frame and `MIN_FRAMES` rules.
- `req_ready` out 1: buffer can accept a request; equals `~pend_valid`.
- `st` out 2: current state code to the decoder `ST` input.
- `freq` out 2: animation phase to the decoder `FREQ` input.
- `frame_end` out 1: high during the last cycle of each frame.
- `busy` out 1: a request is pending; equals `pend_valid`.

## Operation

Registers: `pre_cnt` (0..DIV-1), `freq`, `st`, `pend_valid`, `pend_st`, `frames` (saturating at MIN_FRAMES).

Derived signals:
- `tick` = (`pre_cnt` == DIV-1).
- `frame_end` = `tick` & (`freq` == 3); combinational from registers.
- `switch_ok` = `frame_end` & `pend_valid` & (`frames`+1 ≥ MIN_FRAMES).

Per-cycle update rules, highest priority first:
1. `reset`: `st`=0, `freq`=0, `pre_cnt`=0, `pend_valid`=0, `pend_st`=0, `frames`=0. Consequently `req_ready`=1, `busy`=0, `frame_end`=0 (for DIV>1).
2. `req_valid` & `req_force`, accepted regardless of `req_ready`:
   - `st`←`req_st`; `freq`, `pre_cnt` and `frames` ← 0.
   - `pend_valid`←0, discarding any pending request.
3. `switch_ok`:
   - `st`←`pend_st`, `pend_valid`←0, `freq`←0, `pre_cnt`←0, `frames`←0.
   - If `pend_st` == `st`, the request is still consumed and the frame count still restarts.
4. Otherwise:
   - `pre_cnt` increments, wrapping to 0 on `tick`.
   - On `tick`, `freq` increments mod 4.
   - On `frame_end`, `frames` increments, saturating at MIN_FRAMES.

Request acceptance (non-force):
- A request is accepted when `req_valid` & ~`req_force` & `req_ready`: `pend_st`←`req_st`, `pend_valid`←1.
- A request accepted in the same cycle as `frame_end` is not eligible for that boundary, because `switch_ok` uses the pre-edge `pend_valid`.
- If `req_valid` is held while `req_ready`=0, the requester must keep `req_st` stable. The block ignores it until ready.
- When a switch clears `pend_valid`, `req_ready` rises on the next cycle. No acceptance is allowed in the switch cycle itself, because `req_ready` was 0.

Arithmetic:
- `freq` is modulo-4.
- `pre_cnt` width is clog2(DIV), minimum 1 bit.
- `frames` width is clog2(MIN_FRAMES+1).

## Timing

- All outputs are registered or derived combinationally from registers only. There is no input-to-output combinational path.
- `req_ready` and `busy` depend only on `pend_valid`.
- `freq` holds each value for exactly DIV cycles; one frame lasts 4·DIV cycles.
- A non-force request takes effect at the first eligible frame boundary after acceptance:
  - the new `st` appears with `freq`=0 on the cycle after `frame_end`;
  - the request is always latched by the edge ending its accept cycle.
- Force latency: the new `st` and `freq`=0 are visible one cycle after `req_valid`&`req_force` is sampled.
- DIV=1: `tick` is high every cycle, `freq` steps every cycle, and `frame_end` is high whenever `freq`==3.
- Reset mid-frame or mid-pending: everything returns to reset values on the next edge, and the pending request is lost.

## Test plan

All scenarios use DIV=4, MIN_FRAMES=1 unless stated; cycle 0 is the first cycle after reset deasserts.

- **Reset and free run:** `freq` = 0 in cycles 0–3, 1 in 4–7, 2 in 8–11, 3 in 12–15, then 0 again in cycle 16. `frame_end` is high only in cycle 15 (and every 16 cycles after). `st`=0 throughout; `req_ready`=1.
- **Deferred switch:** `req_valid`=1, `req_st`=2 in cycle 2 → `busy`=1 and `req_ready`=0 in cycles 3–15. `st`=2 with `freq`=0 in cycle 16; `req_ready`=1 in cycle 16.
- **MIN_FRAMES=2:** request `st`=1 in cycle 2 → no switch at cycle 15. `st`=1 appears in cycle 32.
- **Backpressure:** first request (`st`=2) in cycle 2; second request (`st`=3) held from cycle 3 → second not accepted until cycle 16. `st`=2 in 16–31, `st`=3 from cycle 32.
- **Force:**
  - With `st`=2 pending, `req_force`=1 with `req_st`=3 in cycle 6 → cycle 7 shows `st`=3, `freq`=0, `busy`=0.
  - `frame_end` then occurs in cycle 22.
- **Reset mid-operation:** pending request plus `freq`=2, then `reset` for one cycle → next cycle `st`=0, `freq`=0, `busy`=0, `req_ready`=1. The request does not reappear.

Source files
------------

// File: rtl/controlador_segmentos.sv
// Display sequencer for the 7-segment decoder: drives the state code (st) and
// the animation phase (freq), switching st only on frame boundaries.
module controlador_segmentos #(
    parameter int DIV        = 4,
    parameter int MIN_FRAMES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_st,
    input  logic       req_force,
    output logic       req_ready,
    output logic [1:0] st,
    output logic [1:0] freq,
    output logic       frame_end,
    output logic       busy
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = $clog2(MIN_FRAMES + 1);
    localparam logic [PW-1:0] PRE_MAX    = PW'(DIV - 1);
    localparam logic [FW-1:0] FRAMES_MAX = FW'(MIN_FRAMES);

    logic [PW-1:0] pre_cnt;
    logic [FW-1:0] frames;
    logic          pend_valid;
    logic [1:0]    pend_st;
    logic          tick;
    logic          frames_met;
    logic          switch_ok;
    logic          force_req;
    logic          accept;

    assign tick       = (pre_cnt == PRE_MAX);
    assign frame_end  = tick && (freq == 2'd3);
    assign frames_met = ({1'b0, frames} + (FW+1)'(1)) >= {1'b0, FRAMES_MAX};
    assign switch_ok  = frame_end && pend_valid && frames_met;

    // Request handshake: a non-force request transfers on any cycle where
    // req_valid && req_ready; req_ready depends only on the pending register,
    // so the requester must hold req_st stable while req_valid is waiting.
    // A force request (req_valid && req_force) is taken unconditionally.
    assign force_req = req_valid && req_force;
    assign accept    = req_valid && !req_force && !pend_valid;
    assign req_ready = !pend_valid;
    assign busy      = pend_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= 2'd0;
            freq       <= 2'd0;
            pre_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_st    <= 2'd0;
            frames     <= '0;
        end else if (force_req) begin
            st         <= req_st;
            freq       <= 2'd0;
            pre_cnt    <= '0;
            frames     <= '0;
            pend_valid <= 1'b0;
        end else if (switch_ok) begin
            // pend_valid was set, so no new request can be accepted here
            st         <= pend_st;
            freq       <= 2'd0;
            pre_cnt    <= '0;
            frames     <= '0;
            pend_valid <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick)
                freq <= freq + 2'd1;
            if (frame_end && (frames != FRAMES_MAX))
                frames <= frames + FW'(1);
            if (accept) begin
                pend_valid <= 1'b1;
                pend_st    <= req_st;
            end
        end
    end

endmodule

// File: tb/tb_controlador_segmentos.sv
// Scoreboard bench for controlador_segmentos: three parameterisations share one
// stimulus stream; expected per-cycle outputs are queued and checked by a monitor.
module tb_controlador_segmentos;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_st = 2'd0;
    logic       req_force = 1'b0;

    logic       rdy_a, fe_a, busy_a;
    logic [1:0] st_a, freq_a;
    logic       rdy_b, fe_b, busy_b;
    logic [1:0] st_b, freq_b;
    logic       rdy_c, fe_c, busy_c;
    logic [1:0] st_c, freq_c;

    int cyc = 0;
    bit in_reset = 1'b1;
    int checks = 0;
    int errors = 0;

    // entry layout: cyc[24:13] tag[12:9] dut[8:7] {st,freq,frame_end,busy,req_ready}[6:0]
    logic [24:0] exp_q[$];
    logic [24:0] mon_e;
    logic [6:0]  mon_act;

    always #5 clk = ~clk;

    controlador_segmentos #(.DIV(4), .MIN_FRAMES(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_st(req_st),
        .req_force(req_force), .req_ready(rdy_a), .st(st_a), .freq(freq_a),
        .frame_end(fe_a), .busy(busy_a)
    );

    controlador_segmentos #(.DIV(4), .MIN_FRAMES(2)) u_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_st(req_st),
        .req_force(req_force), .req_ready(rdy_b), .st(st_b), .freq(freq_b),
        .frame_end(fe_b), .busy(busy_b)
    );

    controlador_segmentos #(.DIV(1), .MIN_FRAMES(1)) u_c (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_st(req_st),
        .req_force(req_force), .req_ready(rdy_c), .st(st_c), .freq(freq_c),
        .frame_end(fe_c), .busy(busy_c)
    );

    function automatic string tag_name(input logic [3:0] t);
        case (t)
            4'd0:    return "free_run_div4";
            4'd1:    return "free_run_min2";
            4'd2:    return "free_run_div1";
            4'd3:    return "deferred_switch";
            4'd4:    return "min_frames2";
            4'd5:    return "backpressure";
            4'd6:    return "force";
            4'd7:    return "reset_mid";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [6:0] vec(input int s, input int f, input bit fe,
                                       input bit b, input bit r);
        logic [1:0] s2;
        logic [1:0] f2;
        s2 = s[1:0];
        f2 = f[1:0];
        return {s2, f2, fe, b, r};
    endfunction

    task automatic push(input int c, input int tag, input int d, input logic [6:0] v);
        logic [11:0] c12;
        logic [3:0]  t4;
        logic [1:0]  d2;
        c12 = c[11:0];
        t4  = tag[3:0];
        d2  = d[1:0];
        exp_q.push_back({c12, t4, d2, v});
    endtask

    // Monitor: compares every queued expectation due in the current cycle.
    always @(negedge clk) begin
        if (!in_reset) begin
            while (exp_q.size() > 0 && int'(exp_q[0][24:13]) <= cyc) begin
                mon_e = exp_q.pop_front();
                case (mon_e[8:7])
                    2'd0:    mon_act = {st_a, freq_a, fe_a, busy_a, rdy_a};
                    2'd1:    mon_act = {st_b, freq_b, fe_b, busy_b, rdy_b};
                    default: mon_act = {st_c, freq_c, fe_c, busy_c, rdy_c};
                endcase
                checks++;
                if (int'(mon_e[24:13]) < cyc) begin
                    errors++;
                    $display("FAIL %s dut=%0d cyc=%0d missed at cyc=%0d",
                             tag_name(mon_e[12:9]), mon_e[8:7], mon_e[24:13], cyc);
                end else if (mon_act !== mon_e[6:0]) begin
                    errors++;
                    $display("FAIL %s dut=%0d cyc=%0d got st=%0d freq=%0d fe=%0b busy=%0b rdy=%0b expected st=%0d freq=%0d fe=%0b busy=%0b rdy=%0b",
                             tag_name(mon_e[12:9]), mon_e[8:7], cyc,
                             mon_act[6:5], mon_act[4:3], mon_act[2], mon_act[1], mon_act[0],
                             mon_e[6:5], mon_e[4:3], mon_e[2], mon_e[1], mon_e[0]);
                end
            end
        end
    end

    task automatic flush_missed();
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s dut=%0d cyc=%0d never checked",
                     tag_name(mon_e[12:9]), mon_e[8:7], mon_e[24:13]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        flush_missed();
        req_valid = 1'b0;
        req_force = 1'b0;
        req_st    = 2'd0;
        reset     = 1'b1;
        in_reset  = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_reset = 1'b0;
        cyc      = 0;
    endtask

    task automatic send(input logic [1:0] s, input bit f);
        req_valid = 1'b1;
        req_st    = s;
        req_force = f;
        step();
        req_valid = 1'b0;
        req_force = 1'b0;
    endtask

    initial begin
        // Reset and free run on all three parameterisations
        do_reset();
        for (int c = 0; c < 20; c++) begin
            push(c, 0, 0, vec(0, (c / 4) % 4, c == 15, 0, 1));
            push(c, 1, 1, vec(0, (c / 4) % 4, c == 15, 0, 1));
            if (c < 8)
                push(c, 2, 2, vec(0, c % 4, (c % 4) == 3, 0, 1));
        end
        push(31, 0, 0, vec(0, 3, 1, 0, 1));
        run_to(33);

        // Deferred switch on DIV=4/MIN=1
        do_reset();
        push(2, 3, 0, vec(0, 0, 0, 0, 1));
        for (int c = 3; c < 16; c++)
            push(c, 3, 0, vec(0, c / 4, c == 15, 1, 0));
        push(16, 3, 0, vec(2, 0, 0, 0, 1));
        run_to(2);
        send(2'd2, 1'b0);
        run_to(18);

        // MIN_FRAMES=2 holds the request one extra frame
        do_reset();
        push(3, 4, 1, vec(0, 0, 0, 1, 0));
        push(15, 4, 1, vec(0, 3, 1, 1, 0));
        push(16, 3, 0, vec(1, 0, 0, 0, 1));
        push(16, 4, 1, vec(0, 0, 0, 1, 0));
        push(31, 4, 1, vec(0, 3, 1, 1, 0));
        push(32, 4, 1, vec(1, 0, 0, 0, 1));
        run_to(2);
        send(2'd1, 1'b0);
        run_to(34);

        // Backpressure: second request held until ready returns
        do_reset();
        push(3, 5, 0, vec(0, 0, 0, 1, 0));
        push(15, 5, 0, vec(0, 3, 1, 1, 0));
        push(16, 5, 0, vec(2, 0, 0, 0, 1));
        push(17, 5, 0, vec(2, 0, 0, 1, 0));
        push(20, 5, 0, vec(2, 1, 0, 1, 0));
        push(31, 5, 0, vec(2, 3, 1, 1, 0));
        push(32, 5, 0, vec(3, 0, 0, 0, 1));
        run_to(2);
        req_valid = 1'b1;
        req_st    = 2'd2;
        step();
        req_st = 2'd3;
        run_to(17);
        req_valid = 1'b0;
        run_to(34);

        // Force overrides a pending request and restarts the frame
        do_reset();
        push(6, 6, 0, vec(0, 1, 0, 1, 0));
        push(7, 6, 0, vec(3, 0, 0, 0, 1));
        push(21, 6, 0, vec(3, 3, 0, 0, 1));
        push(22, 6, 0, vec(3, 3, 1, 0, 1));
        push(23, 6, 0, vec(3, 0, 0, 0, 1));
        run_to(2);
        send(2'd2, 1'b0);
        run_to(6);
        send(2'd3, 1'b1);
        run_to(25);

        // Reset mid-frame with a pending request
        do_reset();
        push(9, 7, 0, vec(0, 2, 0, 1, 0));
        push(10, 7, 0, vec(0, 0, 0, 0, 1));
        push(25, 7, 0, vec(0, 3, 1, 0, 1));
        push(26, 7, 0, vec(0, 0, 0, 0, 1));
        run_to(2);
        send(2'd1, 1'b0);
        run_to(9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run_to(28);

        flush_missed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
